// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: CSR map, register bit
// positions, FSM state type and the pattern table entry layout.
package led_seq_pkg;

  // CSR word addresses; address 7 is reserved
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_LEN      = 3'd2;
  localparam logic [2:0] ADDR_TICK_DIV = 3'd3;
  localparam logic [2:0] ADDR_TBL_ADDR = 3'd4;
  localparam logic [2:0] ADDR_TBL_DATA = 3'd5;
  localparam logic [2:0] ADDR_MANUAL   = 3'd6;

  // CTRL bits
  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_LOOP   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int unsigned STATUS_BUSY  = 0;
  localparam int unsigned STATUS_DONE  = 1;
  localparam int unsigned STATUS_INDEX = 8;

  // TBL_DATA layout: hold sits above the pattern byte
  localparam int unsigned HOLD_LSB = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWrite,
    StHold
  } seq_state_e;

  typedef struct packed {
    logic [7:0] hold;
    logic [7:0] pattern;
  } seq_entry_t;

endpackage

// File: rtl/led_seq_table.sv
// Pattern table: simple dual-port RAM, CSR-side write port and a registered
// read port used by the sequencer's FETCH cycle. Contents are not reset.
module led_seq_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // CSR write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer: plays a programmable {hold, pattern} table
// onto the LED PIO s1 slave, with a manual-write path while idle.
// Optional feature macro: LED_SEQ_IRQ_EN adds the irq port and CTRL.irq_en.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PATTERN_W = 8,
  parameter int unsigned HOLD_W    = 8,
  parameter int unsigned DIV_W     = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned LEN_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = HOLD_W + PATTERN_W;

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d, tbl_addr_q;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d, tick_div_q, div_eff;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d, hold_eff;
  logic [LEN_W-1:0]     len_q, len_wdata;
  logic [PATTERN_W-1:0] manual_q;
  logic                 manual_stb_q, run_q, loop_q, done_q;
  logic                 done_set, run_clr, busy, last_entry;
  logic                 csr_wr, ctrl_wr, status_wr, len_wr, div_wr, taddr_wr, tdata_wr, manual_wr;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [HOLD_W-1:0]    rd_hold;
  logic [PATTERN_W-1:0] rd_pattern;
`ifdef LED_SEQ_IRQ_EN
  logic                 irq_en_q, irq_q;
`endif

  assign csr_wr    = chipselect & ~write_n;
  assign ctrl_wr   = csr_wr && (address == ADDR_CTRL);
  assign status_wr = csr_wr && (address == ADDR_STATUS);
  assign len_wr    = csr_wr && (address == ADDR_LEN);
  assign div_wr    = csr_wr && (address == ADDR_TICK_DIV);
  assign taddr_wr  = csr_wr && (address == ADDR_TBL_ADDR);
  assign tdata_wr  = csr_wr && (address == ADDR_TBL_DATA);
  assign manual_wr = csr_wr && (address == ADDR_MANUAL);

  assign busy       = (state_q != StIdle);
  assign len_wdata  = (writedata > 32'(DEPTH)) ? LEN_W'(DEPTH) : writedata[LEN_W-1:0];
  assign div_eff    = (tick_div_q == '0) ? DIV_W'(1) : tick_div_q;
  assign {rd_hold, rd_pattern} = rd_entry;
  assign hold_eff   = (rd_hold == '0) ? HOLD_W'(1) : rd_hold;
  // Compared against the live LEN so a mid-run LEN write applies at the next entry end
  assign last_entry = ({1'b0, index_q} + LEN_W'(1)) >= len_q;
  assign pio_address = 2'b00;

  led_seq_table #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_table (
    .clk  (clk),
    .we   (tdata_wr),
    .waddr(tbl_addr_q),
    .wdata({writedata[HOLD_LSB +: HOLD_W], writedata[PATTERN_W-1:0]}),
    .re   (state_q == StFetch),
    .raddr(index_q),
    .rdata(rd_entry)
  );

  // Sequencer next-state: fetch, strobe, hold for hold*div cycles, advance
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tick_cnt_d = tick_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_set   = 1'b0;
    run_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_wr && writedata[CTRL_RUN]) begin
          if (len_q != '0) begin
            index_d = '0;
            state_d = StFetch;
          end else begin
            done_set = 1'b1;
            run_clr  = 1'b1;
          end
        end
      end
      StFetch: state_d = StWrite;
      StWrite: begin
        tick_cnt_d = div_eff - DIV_W'(1);
        hold_cnt_d = hold_eff - HOLD_W'(1);
        state_d    = StHold;
      end
      StHold: begin
        if (tick_cnt_q != '0) begin
          tick_cnt_d = tick_cnt_q - DIV_W'(1);
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          tick_cnt_d = div_eff - DIV_W'(1);
        end else if (!last_entry) begin
          index_d = index_q + IDX_W'(1);
          state_d = StFetch;
        end else if (loop_q) begin
          index_d = '0;
          state_d = StFetch;
        end else begin
          done_set = 1'b1;
          run_clr  = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A run=0 write aborts from any state without reporting completion
    if (ctrl_wr && !writedata[CTRL_RUN]) begin
      state_d  = StIdle;
      done_set = 1'b0;
      run_clr  = 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      index_q    <= '0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // CSR registers and manual-write capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      loop_q       <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= '0;
      tick_div_q   <= '0;
      tbl_addr_q   <= '0;
      manual_q     <= '0;
      manual_stb_q <= 1'b0;
`ifdef LED_SEQ_IRQ_EN
      irq_en_q     <= 1'b0;
`endif
    end else begin
      if (ctrl_wr) begin
        run_q  <= writedata[CTRL_RUN];
        loop_q <= writedata[CTRL_LOOP];
`ifdef LED_SEQ_IRQ_EN
        irq_en_q <= writedata[CTRL_IRQ_EN];
`endif
      end
      if (run_clr) run_q <= 1'b0;
      if (len_wr) len_q <= len_wdata;
      if (div_wr) tick_div_q <= writedata[DIV_W-1:0];
      if (taddr_wr) tbl_addr_q <= writedata[IDX_W-1:0];
      else if (tdata_wr) tbl_addr_q <= tbl_addr_q + IDX_W'(1);
      // Set beats a simultaneous write-1-to-clear
      if (done_set) done_q <= 1'b1;
      else if (status_wr && writedata[STATUS_DONE]) done_q <= 1'b0;
      manual_stb_q <= manual_wr && !busy;
      if (manual_wr && !busy) manual_q <= writedata[PATTERN_W-1:0];
    end
  end

`ifdef LED_SEQ_IRQ_EN
  // Interrupt follows done one cycle later but drops on the same edge as a done clear
  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= done_q & irq_en_q & ~(status_wr & writedata[STATUS_DONE]);
  end
  assign irq = irq_q;
`endif

  // CSR read mux, zero-extended
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN]  = run_q;
        readdata[CTRL_LOOP] = loop_q;
`ifdef LED_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN] = irq_en_q;
`else
        readdata[CTRL_IRQ_EN] = 1'b0;
`endif
      end
      ADDR_STATUS: begin
        readdata[STATUS_BUSY]            = busy;
        readdata[STATUS_DONE]            = done_q;
        readdata[STATUS_INDEX +: IDX_W]  = index_q;
      end
      ADDR_LEN:      readdata[LEN_W-1:0]     = len_q;
      ADDR_TICK_DIV: readdata[DIV_W-1:0]     = tick_div_q;
      ADDR_TBL_ADDR: readdata[IDX_W-1:0]     = tbl_addr_q;
      ADDR_MANUAL:   readdata[PATTERN_W-1:0] = manual_q;
      default:       readdata = '0;
    endcase
  end

  // PIO s1 strobe: sequencer WRITE cycle or a pending manual write
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    if (state_q == StWrite) begin
      pio_chipselect               = 1'b1;
      pio_write_n                  = 1'b0;
      pio_writedata[PATTERN_W-1:0] = rd_pattern;
    end else if (manual_stb_q) begin
      pio_chipselect               = 1'b1;
      pio_write_n                  = 1'b0;
      pio_writedata[PATTERN_W-1:0] = manual_q;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a reference model predicts every PIO strobe
// (pattern and cycle) into a queue; a monitor pops and compares on each strobe.
// Define LED_SEQ_IRQ_EN for both bench and RTL to exercise the interrupt.
module tb_led_pattern_sequencer;

  logic        clk, reset_n, chipselect, write_n;
  logic [2:0]  address;
  logic [31:0] writedata, readdata, pio_writedata;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  led_pattern_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .pio_address   (pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n   (pio_write_n),
    .pio_writedata (pio_writedata)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pat;
    int t;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   strobe_t[$];
  int   strobe_cnt = 0;

  // Reference model of the programmable state
  int tbl_hold[16];
  int tbl_pat[16];
  int tptr_m = 0;
  int len_m  = 0;
  int div_m  = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (pio_chipselect) begin
      strobe_cnt++;
      strobe_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got pattern 0x%0h at cycle %0d, required no strobe",
                 pio_writedata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_pattern", pio_writedata, mon_e.pat);
        check("strobe_cycle", cyc, mon_e.t);
        check("strobe_write_n", pio_write_n, 0);
        check("strobe_address", pio_address, 0);
      end
    end
  end

  task automatic wr_begin(input int a, input int d);
    @(negedge clk);
    address = a[2:0]; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    case (a)
      2: len_m = (d > 16) ? 16 : d;
      3: div_m = d & 32'hFF_FFFF;
      4: tptr_m = d & 15;
      5: begin
        tbl_hold[tptr_m] = (d >> 8) & 8'hFF;
        tbl_pat[tptr_m]  = d & 8'hFF;
        tptr_m = (tptr_m + 1) % 16;
      end
      default: ;
    endcase
  endtask

  task automatic wr_end();
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    wr_begin(a, d);
    wr_end();
  endtask

  // Read at the current falling edge
  task automatic rd_now(input int a, output int v);
    address = a[2:0];
    #1 v = readdata;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending strobes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Write CTRL and predict the strobe train from the table rules:
  // first strobe two cycles after the write, then hold*div + 2 apart.
  task automatic run_seq(input int ctrl, input int max_s, output int end_t);
    int t, i, n, hd;
    wr_begin(0, ctrl);
    t = cyc + 2; end_t = cyc + 1; i = 0; n = 0; hd = 0;
    if (len_m != 0) begin
      while (n < max_s) begin
        exp_q.push_back('{pat: tbl_pat[i], t: t});
        hd = (tbl_hold[i] == 0 ? 1 : tbl_hold[i]) * (div_m == 0 ? 1 : div_m);
        n++;
        end_t = t + hd + 1;
        if (i + 1 < len_m) i++;
        else if (ctrl[1]) i = 0;
        else break;
        t = t + hd + 2;
      end
    end
    wr_end();
  endtask

  initial begin
    int end_t, v, n0, len_r, div_r, h, p;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_pio_cs", pio_chipselect, 0);
    check("reset_pio_write_n", pio_write_n, 1);
    check("reset_pio_data", pio_writedata, 0);
    for (int a = 0; a < 8; a++) begin
      rd_now(a, v);
      check($sformatf("reset_reg%0d", a), v, 0);
    end
    reset_n = 1'b1;

    // Three-entry single pass
    wr(4, 0); wr(5, 'h101); wr(5, 'h202); wr(5, 'h104); wr(2, 3); wr(3, 4);
    strobe_t.delete();
    run_seq(1, 100, end_t);
    wait_until(end_t - 1);
    rd_now(1, v); check("t1_busy_before_end", v & 3, 1);
    @(negedge clk);
    rd_now(1, v); check("t1_done", v & 3, 2);
    check("t1_strobe_count", strobe_t.size(), 3);
    if (strobe_t.size() == 3) begin
      check("t1_spacing_a", strobe_t[1] - strobe_t[0], 6);
      check("t1_spacing_b", strobe_t[2] - strobe_t[1], 10);
    end

    // Looping, stopped after seven strobes
    wr(1, 2);
    rd_now(1, v); check("t2_done_cleared", v & 2, 0);
    n0 = strobe_cnt;
    run_seq(3, 7, end_t);
    wait_drain(200);
    wr(0, 0);
    repeat (30) @(negedge clk);
    check("t2_strobe_total", strobe_cnt - n0, 7);
    rd_now(1, v); check("t2_status_after_stop", v & 3, 0);

    // Empty run
    wr(2, 0);
    run_seq(1, 100, end_t);
    rd_now(1, v); check("t3_done_next_cycle", v & 3, 2);
    rd_now(0, v); check("t3_run_cleared", v, 0);
    repeat (5) @(negedge clk);

    // Manual writes: idle then busy
    wr(1, 2);
    wr_begin(6, 'hA5);
    exp_q.push_back('{pat: 'hA5, t: cyc + 1});
    wr_end();
    wait_drain(5);
    wr(4, 0); wr(5, (50 << 8) | 'h81); wr(2, 1); wr(3, 1);
    run_seq(1, 1, end_t);
    wait_drain(10);
    wr(6, 'h5A);
    repeat (3) @(negedge clk);
    rd_now(6, v); check("t4_manual_ignored", v, 'hA5);
    rd_now(1, v); check("t4_still_busy", v & 1, 1);
    wr(0, 0);
    rd_now(1, v); check("t4_stopped", v & 3, 0);

    // Reset mid-HOLD
    wr(4, 0); wr(5, (50 << 8) | 'h3C); wr(2, 1); wr(3, 2);
    run_seq(1, 1, end_t);
    wait_drain(10);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t5_pio_cs", pio_chipselect, 0);
    check("t5_pio_write_n", pio_write_n, 1);
    check("t5_pio_data", pio_writedata, 0);
    rd_now(1, v); check("t5_status", v, 0);
    rd_now(0, v); check("t5_ctrl", v, 0);
    rd_now(2, v); check("t5_len", v, 0);
    len_m = 0; div_m = 0; tptr_m = 0;
    repeat (120) @(negedge clk);

    // Table survives reset
    wr(2, 1);
    run_seq(1, 100, end_t);
    wait_until(end_t);
    rd_now(1, v); check("t5_table_kept_done", v & 3, 2);

    // LEN clamp and table pointer wrap
    wr(2, 200);
    rd_now(2, v); check("len_clamp", v, 16);
    wr(4, 15); wr(5, 'h0377);
    rd_now(4, v); check("tbl_addr_wrap", v, tptr_m);

    // Randomized single passes
    for (int it = 0; it < 6; it++) begin
      wr(1, 2);
      wr(4, 0);
      for (int k = 0; k < 5; k++) begin
        h = $urandom_range(0, 3);
        p = $urandom_range(0, 255);
        wr(5, (h << 8) | p);
      end
      len_r = $urandom_range(1, 5);
      div_r = $urandom_range(0, 3);
      wr(2, len_r); wr(3, div_r);
      run_seq(1, 100, end_t);
      wait_until(end_t - 1);
      rd_now(1, v); check("rand_busy", v & 1, 1);
      @(negedge clk);
      rd_now(1, v); check("rand_done", v & 3, 2);
      wait_drain(10);
    end

`ifdef LED_SEQ_IRQ_EN
    wr(1, 2); wr(4, 0); wr(5, 'h0111); wr(2, 1); wr(3, 1);
    run_seq(5, 100, end_t);
    wait_until(end_t);
    rd_now(1, v); check("irq_done_set", v & 2, 2);
    check("irq_lags_done", irq, 0);
    @(negedge clk);
    check("irq_rise", irq, 1);
    wr(1, 2);
    check("irq_clear", irq, 0);
    rd_now(1, v); check("irq_done_clear", v & 2, 0);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
